// File: rtl/mecobo_pkg.sv
// Shared mecobo definitions: serializer state encoding, packet length and the
// latched sample record.
package mecobo_pkg;

  localparam logic [2:0] PKT_WORDS = 3'd4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_TH   = 3'd2;
  localparam logic [2:0] ST_TL   = 3'd3;
  localparam logic [2:0] ST_VAL  = PKT_WORDS;

  typedef struct packed {
    logic [7:0]  channel;
    logic [15:0] value;
    logic [31:0] tstamp;
  } sample_t;

endpackage

// File: rtl/sample_serializer.sv
// Serializes accepted samples into four 16-bit words (header, time high,
// time low, value) for the EBI-side sample FIFO.
module sample_serializer
  import mecobo_pkg::*;
#(
  parameter int POSITION = 242,
  parameter int SEQ_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_bus_en,
  input  logic        cmd_bus_wr,
  input  logic [15:0] cmd_bus_addr,
  input  logic [31:0] cmd_bus_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_channel,
  input  logic [15:0] in_value,
  input  logic [31:0] in_time,
  output logic [15:0] out_data,
  output logic        out_wr,
  input  logic        out_full,
  output logic        busy,
  output logic [15:0] pkt_count
);

  logic [2:0]       state_r;
  logic [2:0]       state_nx_s;
  logic             enable_r;
  logic [SEQ_W-1:0] seq_r;
  logic [SEQ_W-1:0] seq_lat_r;
  logic [15:0]      pkt_count_r;
  sample_t          sample_r;
  logic             cfg_wr_s;
  logic             clear_s;
  logic             accept_s;
  logic             out_wr_s;
  logic             val_wr_s;
  logic             unused_s;

  assign cfg_wr_s = cmd_bus_en & cmd_bus_wr & (cmd_bus_addr == 16'(POSITION));
  assign clear_s  = cfg_wr_s & cmd_bus_data[1];
  assign unused_s = ^cmd_bus_data[31:2];

  assign in_ready  = (state_r == ST_IDLE) & enable_r;
  assign accept_s  = in_valid & in_ready;
  assign out_wr_s  = (state_r != ST_IDLE) & ~out_full;
  assign val_wr_s  = (state_r == ST_VAL) & out_wr_s;
  assign out_wr    = out_wr_s;
  assign busy      = (state_r != ST_IDLE);
  assign pkt_count = pkt_count_r;

  // Next-state: each word state only moves on once its word is written.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nx_s = ST_HDR;
        else          state_nx_s = ST_IDLE;
      end
      ST_HDR: begin
        if (out_wr_s) state_nx_s = ST_TH;
        else          state_nx_s = ST_HDR;
      end
      ST_TH: begin
        if (out_wr_s) state_nx_s = ST_TL;
        else          state_nx_s = ST_TH;
      end
      ST_TL: begin
        if (out_wr_s) state_nx_s = ST_VAL;
        else          state_nx_s = ST_TL;
      end
      ST_VAL: begin
        if (out_wr_s) state_nx_s = ST_IDLE;
        else          state_nx_s = ST_VAL;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register; reset abandons any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nx_s;
  end

  // Enable bit from the config register; the clear bit is never stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           enable_r <= 1'b0;
    else if (cfg_wr_s) enable_r <= cmd_bus_data[0];
    else               enable_r <= enable_r;
  end

  // Sequence and packet counters; a clear beats the VAL-write increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_r       <= '0;
      pkt_count_r <= 16'd0;
    end else begin
      if (clear_s)       seq_r <= '0;
      else if (val_wr_s) seq_r <= seq_r + SEQ_W'(1);
      else               seq_r <= seq_r;
      if (val_wr_s) pkt_count_r <= pkt_count_r + 16'd1;
      else          pkt_count_r <= pkt_count_r;
    end
  end

  // Capture the sample and the seq it travels with at accept time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_r  <= '0;
      seq_lat_r <= '0;
    end else if (accept_s) begin
      sample_r.channel <= in_channel;
      sample_r.value   <= in_value;
      sample_r.tstamp  <= in_time;
      seq_lat_r        <= seq_r;
    end else begin
      sample_r  <= sample_r;
      seq_lat_r <= seq_lat_r;
    end
  end

  // Word mux; the header carries the seq low byte, zero-extended if narrower.
  always_comb begin
    out_data = 16'd0;
    case (state_r)
      ST_HDR:  out_data = {sample_r.channel, 8'(seq_lat_r)};
      ST_TH:   out_data = sample_r.tstamp[31:16];
      ST_TL:   out_data = sample_r.tstamp[15:0];
      ST_VAL:  out_data = sample_r.value;
      default: out_data = 16'd0;
    endcase
  end

endmodule

// File: tb/tb_sample_serializer.sv
// Directed self-checking bench for sample_serializer.
module tb_sample_serializer;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        cmd_bus_en, cmd_bus_wr;
  logic [15:0] cmd_bus_addr;
  logic [31:0] cmd_bus_data;
  logic        in_valid, in_ready;
  logic [7:0]  in_channel;
  logic [15:0] in_value;
  logic [31:0] in_time;
  logic [15:0] out_data;
  logic        out_wr, out_full, busy;
  logic [15:0] pkt_count;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_seq;
  logic [15:0] exp_cnt;

  sample_serializer #(.POSITION(242), .SEQ_W(8)) dut (
    .clk(sys_clk), .rst(rst),
    .cmd_bus_en(cmd_bus_en), .cmd_bus_wr(cmd_bus_wr),
    .cmd_bus_addr(cmd_bus_addr), .cmd_bus_data(cmd_bus_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_channel(in_channel), .in_value(in_value), .in_time(in_time),
    .out_data(out_data), .out_wr(out_wr), .out_full(out_full),
    .busy(busy), .pkt_count(pkt_count)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_drive(input logic [15:0] addr, input logic [31:0] data);
    cmd_bus_en   = 1'b1;
    cmd_bus_wr   = 1'b1;
    cmd_bus_addr = addr;
    cmd_bus_data = data;
  endtask

  task automatic cfg_idle();
    cmd_bus_en = 1'b0;
    cmd_bus_wr = 1'b0;
  endtask

  task automatic start_pkt(input logic [7:0] ch, input logic [15:0] val, input logic [31:0] tm);
    in_channel = ch;
    in_value   = val;
    in_time    = tm;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
  endtask

  // One full packet with no back-pressure; header seq comes from exp_seq.
  task automatic run_pkt(input logic [7:0] ch, input logic [15:0] val,
                         input logic [31:0] tm, input bit do_chk);
    if (do_chk) chk("pkt_ready", 32'(in_ready), 32'd1);
    start_pkt(ch, val, tm);
    if (do_chk) chk("pkt_hdr", 32'(out_data), {16'd0, ch, exp_seq});
    if (do_chk) chk("pkt_hdr_wr", 32'(out_wr), 32'd1);
    tick();
    if (do_chk) chk("pkt_th", 32'(out_data), {16'd0, tm[31:16]});
    tick();
    if (do_chk) chk("pkt_tl", 32'(out_data), {16'd0, tm[15:0]});
    tick();
    if (do_chk) chk("pkt_val", 32'(out_data), {16'd0, val});
    tick();
    exp_seq = exp_seq + 8'd1;
    exp_cnt = exp_cnt + 16'd1;
    if (do_chk) chk("pkt_count", 32'(pkt_count), {16'd0, exp_cnt});
  endtask

  initial begin
    rst = 1'b1;
    cmd_bus_en = 1'b0; cmd_bus_wr = 1'b0; cmd_bus_addr = 16'd0; cmd_bus_data = 32'd0;
    in_valid = 1'b0; in_channel = 8'd0; in_value = 16'd0; in_time = 32'd0;
    out_full = 1'b0;
    #2;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_wr", 32'(out_wr), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(pkt_count), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Wrong address must not enable, right address does, wrong address cannot disable
    cfg_drive(16'd243, 32'd1); tick(); cfg_idle();
    chk("addr_plus1_en", 32'(in_ready), 32'd0);
    cfg_drive(16'd242, 32'd1); tick(); cfg_idle();
    chk("enable", 32'(in_ready), 32'd1);
    cfg_drive(16'd243, 32'd0); tick(); cfg_idle();
    chk("addr_plus1_dis", 32'(in_ready), 32'd1);

    // Basic packet, first word one cycle after accept
    start_pkt(8'h03, 16'h0ABC, 32'h12345678);
    chk("a_busy", 32'(busy), 32'd1);
    chk("a_ready", 32'(in_ready), 32'd0);
    chk("a_hdr_wr", 32'(out_wr), 32'd1);
    chk("a_hdr", 32'(out_data), 32'h0300);
    tick(); chk("a_th", 32'(out_data), 32'h1234); chk("a_th_wr", 32'(out_wr), 32'd1);
    tick(); chk("a_tl", 32'(out_data), 32'h5678); chk("a_tl_wr", 32'(out_wr), 32'd1);
    tick(); chk("a_val", 32'(out_data), 32'h0ABC); chk("a_val_wr", 32'(out_wr), 32'd1);
    tick();
    chk("a_idle_wr", 32'(out_wr), 32'd0);
    chk("a_idle_busy", 32'(busy), 32'd0);
    chk("a_count", 32'(pkt_count), 32'd1);

    // Back-pressure for three cycles during TL
    start_pkt(8'h11, 16'hBEEF, 32'hCAFE5678);
    chk("b_hdr", 32'(out_data), 32'h1101);
    tick(); chk("b_th", 32'(out_data), 32'hCAFE);
    tick(); out_full = 1'b1; #1;
    chk("b_full1_wr", 32'(out_wr), 32'd0); chk("b_full1_data", 32'(out_data), 32'h5678);
    tick();
    chk("b_full2_wr", 32'(out_wr), 32'd0); chk("b_full2_data", 32'(out_data), 32'h5678);
    tick();
    chk("b_full3_wr", 32'(out_wr), 32'd0); chk("b_full3_data", 32'(out_data), 32'h5678);
    tick(); out_full = 1'b0; #1;
    chk("b_tl_wr", 32'(out_wr), 32'd1); chk("b_tl", 32'(out_data), 32'h5678);
    tick(); chk("b_val", 32'(out_data), 32'hBEEF); chk("b_val_wr", 32'(out_wr), 32'd1);
    tick(); chk("b_count", 32'(pkt_count), 32'd2); chk("b_idle_wr", 32'(out_wr), 32'd0);

    exp_seq = 8'd2;
    exp_cnt = 16'd2;
    for (int i = 0; i < 3; i++) run_pkt(8'(8'hA0 + i), 16'(i + 1), 32'h0000_1000 + 32'(i), 1'b1);

    // Clear coincides with the VAL write of the seq=5 packet
    start_pkt(8'h22, 16'h2222, 32'h22223333);
    chk("c_hdr", 32'(out_data), 32'h2205);
    tick(); tick(); tick();
    cfg_drive(16'd242, 32'd3);
    chk("c_val", 32'(out_data), 32'h2222);
    tick(); cfg_idle();
    chk("c_ready", 32'(in_ready), 32'd1);
    chk("c_count", 32'(pkt_count), 32'd6);
    exp_seq = 8'd0;
    exp_cnt = 16'd6;
    run_pkt(8'h33, 16'h3333, 32'h33334444, 1'b1);

    // Clear while the header is held by back-pressure keeps the latched seq
    start_pkt(8'h44, 16'h4444, 32'h44445555);
    out_full = 1'b1;
    cfg_drive(16'd242, 32'd3);
    #1;
    chk("e_full_wr", 32'(out_wr), 32'd0); chk("e_hdr0", 32'(out_data), 32'h4401);
    tick(); cfg_idle();
    chk("e_hdr1", 32'(out_data), 32'h4401); chk("e_busy", 32'(busy), 32'd1);
    out_full = 1'b0; #1;
    chk("e_hdr_wr", 32'(out_wr), 32'd1); chk("e_hdr2", 32'(out_data), 32'h4401);
    tick(); tick(); tick();
    chk("e_val", 32'(out_data), 32'h4444);
    tick();

    // Disable during TH: packet completes, then no further accepts
    start_pkt(8'h55, 16'h5555, 32'h01020304);
    chk("f_hdr", 32'(out_data), 32'h5501);
    tick(); cfg_drive(16'd242, 32'd0);
    chk("f_th", 32'(out_data), 32'h0102);
    tick(); cfg_idle();
    chk("f_tl", 32'(out_data), 32'h0304); chk("f_tl_wr", 32'(out_wr), 32'd1);
    tick(); chk("f_val", 32'(out_data), 32'h5555);
    tick();
    chk("f_ready", 32'(in_ready), 32'd0);
    chk("f_count", 32'(pkt_count), 32'd9);
    in_valid = 1'b1;
    tick(); tick();
    chk("f_no_accept_busy", 32'(busy), 32'd0);
    chk("f_no_accept_ready", 32'(in_ready), 32'd0);
    chk("f_no_accept_wr", 32'(out_wr), 32'd0);
    in_valid = 1'b0;

    // Asynchronous reset during TL
    cfg_drive(16'd242, 32'd1); tick(); cfg_idle();
    start_pkt(8'h66, 16'h6666, 32'h66667777);
    tick(); tick();
    chk("g_tl_wr", 32'(out_wr), 32'd1);
    #2; rst = 1'b1; #1;
    chk("g_rst_wr", 32'(out_wr), 32'd0);
    chk("g_rst_busy", 32'(busy), 32'd0);
    chk("g_rst_ready", 32'(in_ready), 32'd0);
    chk("g_rst_data", 32'(out_data), 32'd0);
    chk("g_rst_count", 32'(pkt_count), 32'd0);
    tick(); rst = 1'b0;
    tick();
    chk("g_post_ready", 32'(in_ready), 32'd0);
    chk("g_post_wr", 32'(out_wr), 32'd0);

    // 257 packets: seq wraps, pkt_count does not
    cfg_drive(16'd242, 32'd1); tick(); cfg_idle();
    exp_seq = 8'd0;
    exp_cnt = 16'd0;
    for (int i = 0; i < 256; i++)
      run_pkt(8'(i), 16'(i * 3), {24'd0, 8'(i)}, (i < 2) || (i >= 254));
    start_pkt(8'h77, 16'h7777, 32'h77778888);
    chk("wrap_hdr", 32'(out_data), 32'h7700);
    tick(); tick(); tick();
    chk("wrap_val", 32'(out_data), 32'h7777);
    tick();
    chk("wrap_count", 32'(pkt_count), 32'd257);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sample_serializer.md
SAMPLE_SERIALIZER -- requirements
Module: sample_serializer

Interface
REQ-001 SHALL have parameter POSITION, default 242, command-bus address of this unit.
REQ-002 SHALL have parameter SEQ_W, default 8, width of the packet sequence counter.
REQ-003 SHALL have port clk  input  1  system clock (sys_clk domain); the block uses only this clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports cmd_bus_en, cmd_bus_wr  input  1 each  command-bus enable and write strobe.
REQ-006 SHALL have ports cmd_bus_addr  input  16, and cmd_bus_data  input  32  command-bus address and data.
REQ-007 SHALL have ports in_valid  input  1, and in_ready  output  1  sample handshake from the sample source.
REQ-008 SHALL have ports in_channel  input  8, in_value  input  16, and in_time  input  32  sample channel, value and global_clock timestamp.
REQ-009 SHALL have ports out_data  output  16, out_wr  output  1, and out_full  input  1  word stream into the EBI-side sample FIFO.
REQ-010 SHALL have ports busy  output  1, and pkt_count  output  16  status outputs.

Function
REQ-011 SHALL decode a config write as cmd_bus_en & cmd_bus_wr & cmd_bus_addr==POSITION: data[0] sets enable; data[1]=1 clears seq (one-shot, not stored).
REQ-012 SHALL use FSM states IDLE, HDR, TH, TL, VAL.
REQ-013 SHALL drive in_ready=1 only in IDLE with enable=1.
REQ-014 SHALL, on in_valid & in_ready, latch channel, value, time and the current seq, then enter HDR next cycle.
REQ-015 SHALL drive out_wr = (state!=IDLE) & !out_full.
REQ-016 SHALL drive out_data combinationally from latched registers: HDR={channel, seq[7:0] zero-extended}; TH=time[31:16]; TL=time[15:0]; VAL=value.
REQ-017 SHALL advance HDR->TH->TL->VAL->IDLE only on cycles where out_wr=1, and hold the state and out_data while out_full=1.
REQ-018 SHALL increment seq (wrapping modulo 2^SEQ_W) and pkt_count (wrapping at 16 bits) on the VAL write cycle.
REQ-019 SHALL give a latency of 1 cycle from accept to first word write, with out_full low; the minimum packet period is 5 cycles.
REQ-020 SHALL let a clear coinciding with the VAL-write increment win (seq=0 after).
REQ-021 SHALL apply clear only to subsequent packets; the in-flight header keeps its latched seq.
REQ-022 SHALL complete an in-flight packet when enable is deasserted mid-packet, then hold in_ready low.
REQ-023 SHALL drive busy=1 whenever state!=IDLE.

Reset
REQ-024 SHALL on rst force state=IDLE, enable=0, seq=0, pkt_count=0, latched data=0, so in_ready=0, out_wr=0, out_data=0, busy=0.
REQ-025 SHALL, on rst mid-packet, abandon the packet with no further words written; a partial packet already in the FIFO is the software's responsibility.

Structure
REQ-026 SHALL place state encoding and the packet word count (4) in the shared mecobo package; POSITION stays a per-instance parameter.
REQ-027 SHALL be a single module with no sub-modules; the config decoder is inline.

Verification
REQ-028 Enable, then sample ch=3, val=0x0ABC, time=0x12345678, out_full=0 -> words 0x0300, 0x1234, 0x5678, 0x0ABC on 4 consecutive cycles starting 1 cycle after accept; pkt_count=1.
REQ-029 out_full high for 3 cycles during TL -> 0x5678 held, out_wr=0 for 3 cycles, then written once; no duplicate or lost words.
REQ-030 Send 257 packets -> 257th header low byte=0x00 (seq wrapped); pkt_count=257.
REQ-031 Clear write on the VAL cycle of packet with seq=5 -> next header seq=0x00; disable mid-TH -> packet finishes and in_ready stays 0.
REQ-032 rst asserted during TL -> out_wr=0 in the same cycle (asynchronous), state IDLE, in_ready=0 until re-enabled.
REQ-033 Config write to address POSITION+1 -> enable unchanged, in_ready unchanged.
